// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment clock display.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int OUT_W = 14;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DIGIT_SEC_LO  = 3'd0;
    localparam logic [2:0] DIGIT_SEC_HI  = 3'd1;
    localparam logic [2:0] DIGIT_MIN_LO  = 3'd2;
    localparam logic [2:0] DIGIT_MIN_HI  = 3'd3;
    localparam logic [2:0] DIGIT_HOUR_LO = 3'd4;
    localparam logic [2:0] DIGIT_HOUR_HI = 3'd5;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_HOUR = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;
    localparam logic [1:0] BLINK_SEC  = 2'b11;

    // Output word is {AN[5:0], Seg[6:0], DP}; inverted as a whole for active-low boards.
    function automatic logic [OUT_W-1:0] apply_pol(input logic active_low,
                                                   input logic [OUT_W-1:0] v);
        if (active_low) begin
            apply_pol = ~v;
        end else begin
            apply_pol = v;
        end
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-high 7-segment pattern; codes A-F render blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Nibble lookup
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed HH.MM.SS driver: scans six digits, snapshotting inputs once per frame.
// Optional field blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLINK_FRAMES = 64
)(
    input  logic       CP,
    input  logic       reset,
    input  logic       EN,
    input  logic [7:0] Hour,
    input  logic [7:0] Min,
    input  logic [7:0] Sec,
`ifdef SEG7_BLINK_EN
    input  logic [1:0] BlinkSel,
`endif
    output logic [5:0] AN,
    output logic [6:0] Seg,
    output logic       DP
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic             AL_B     = (ACTIVE_LOW != 0);
    localparam logic [OUT_W-1:0] OUT_OFF  = apply_pol(AL_B, {OUT_W{1'b0}});

    if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("seg7_scan_display: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [23:0]      snap_r;
    logic [OUT_W-1:0] out_r;
    logic             tick_s;
    logic             frame_end_s;
    logic [3:0]       nib_s;
    logic [6:0]       seg_s;
    logic [5:0]       an_s;
    logic             dp_s;
    logic             blank_s;

    assign tick_s      = EN && (cnt_r == CNT_LAST);
    assign frame_end_s = tick_s && (idx_r == DIGIT_HOUR_HI);

    // Prescaler and digit index
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            idx_r <= DIGIT_SEC_LO;
        end else if (tick_s) begin
            cnt_r <= '0;
            idx_r <= frame_end_s ? DIGIT_SEC_LO : idx_r + 3'd1;
        end else if (EN) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Frame snapshot keeps a whole frame consistent
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            snap_r <= 24'h00_0000;
        end else if (frame_end_s) begin
            snap_r <= {Hour, Min, Sec};
        end
    end

    // Digit select, nibble mux and separator points
    always_comb begin
        nib_s = 4'hF;
        an_s  = 6'b00_0000;
        dp_s  = 1'b0;
        case (idx_r)
            DIGIT_SEC_LO:  begin nib_s = snap_r[3:0];   an_s = 6'b00_0001; end
            DIGIT_SEC_HI:  begin nib_s = snap_r[7:4];   an_s = 6'b00_0010; end
            DIGIT_MIN_LO:  begin nib_s = snap_r[11:8];  an_s = 6'b00_0100; dp_s = 1'b1; end
            DIGIT_MIN_HI:  begin nib_s = snap_r[15:12]; an_s = 6'b00_1000; end
            DIGIT_HOUR_LO: begin nib_s = snap_r[19:16]; an_s = 6'b01_0000; dp_s = 1'b1; end
            DIGIT_HOUR_HI: begin nib_s = snap_r[23:20]; an_s = 6'b10_0000; end
            default:       begin nib_s = 4'hF;          an_s = 6'b00_0000; dp_s = 1'b0; end
        endcase
    end

    seg7_decode u_decode (
        .nibble (nib_s),
        .seg    (seg_s)
    );

`ifdef SEG7_BLINK_EN
    localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_r;
    logic             phase_r;
    logic [1:0]       sel_r;

    // Frame counter toggles blink phase; field select follows the snapshot
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            frm_r   <= '0;
            phase_r <= 1'b0;
            sel_r   <= BLINK_NONE;
        end else if (frame_end_s) begin
            sel_r <= BlinkSel;
            if (frm_r == FRM_LAST) begin
                frm_r   <= '0;
                phase_r <= ~phase_r;
            end else begin
                frm_r <= frm_r + FRM_W'(1);
            end
        end
    end

    // Hide both digits of the selected field during the off phase
    always_comb begin
        blank_s = 1'b0;
        if (phase_r) begin
            case (sel_r)
                BLINK_HOUR: blank_s = (idx_r == DIGIT_HOUR_LO) || (idx_r == DIGIT_HOUR_HI);
                BLINK_MIN:  blank_s = (idx_r == DIGIT_MIN_LO)  || (idx_r == DIGIT_MIN_HI);
                BLINK_SEC:  blank_s = (idx_r == DIGIT_SEC_LO)  || (idx_r == DIGIT_SEC_HI);
                default:    blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    // Registered output stage, frozen while EN is low
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            out_r <= OUT_OFF;
        end else if (EN) begin
            out_r <= apply_pol(AL_B, {(blank_s ? 6'b00_0000 : an_s), seg_s, dp_s});
        end
    end

    assign AN  = out_r[13:8];
    assign Seg = out_r[7:1];
    assign DP  = out_r[0];

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (SCAN_DIV=4, active-low, BLINK_FRAMES=2).
module tb_seg7_scan_display;

    localparam int SCAN_DIV     = 4;
    localparam int ACTIVE_LOW   = 1;
    localparam int BLINK_FRAMES = 2;

    logic       CP = 1'b0;
    logic       reset;
    logic       EN;
    logic [7:0] Hour, Min, Sec;
`ifdef SEG7_BLINK_EN
    logic [1:0] BlinkSel;
`endif
    logic [5:0] AN;
    logic [6:0] Seg;
    logic       DP;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [13:0] exp_q[$];

    localparam logic [13:0] ALL_OFF = 14'h3FFF;

    seg7_scan_display #(
        .SCAN_DIV     (SCAN_DIV),
        .ACTIVE_LOW   (ACTIVE_LOW),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .CP       (CP),
        .reset    (reset),
        .EN       (EN),
        .Hour     (Hour),
        .Min      (Min),
        .Sec      (Sec),
`ifdef SEG7_BLINK_EN
        .BlinkSel (BlinkSel),
`endif
        .AN       (AN),
        .Seg      (Seg),
        .DP       (DP)
    );

    always #5 CP = ~CP;

    // Active-low board patterns {g..a}
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Queue the six expected slot words {AN,Seg,DP} of one frame; blk hides a field.
    function automatic void push_frame(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s, input logic [1:0] blk);
        logic [23:0] v;
        v = {h, m, s};
        for (int k = 0; k < 6; k++) begin
            logic [5:0] an;
            logic       dp;
            logic       hid;
            an  = ~(6'b000001 << k);
            dp  = (k == 2 || k == 4) ? 1'b0 : 1'b1;
            hid = (blk == 2'b01 && k >= 4) || (blk == 2'b10 && (k == 2 || k == 3)) ||
                  (blk == 2'b11 && k <= 1);
            if (hid) an = 6'h3F;
            exp_q.push_back({an, seg_of(v[4*k +: 4]), dp});
        end
    endfunction

    function automatic logic [13:0] take();
        if (exp_q.size() == 0) return 14'bx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            EN = c[0];
            @(posedge CP); @(negedge CP);
            n_checks++;
            if ({AN, Seg, DP} !== ALL_OFF)
                $display("FAIL reset cyc %0d: AN=%h Seg=%h DP=%b want 3f 7f 1", c, AN, Seg, DP);
            else n_pass++;
        end
    endtask

    task automatic test_scan();
        logic [13:0] e;
        exp_q.delete();
        push_frame(8'h00, 8'h00, 8'h00, 2'b00);
        push_frame(8'h12, 8'h34, 8'h56, 2'b00);
        EN = 1'b1;
        reset = 1'b0;
        for (int s = 0; s < 12; s++) begin
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL scan slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [13:0] e;
        push_frame(8'h12, 8'h34, 8'h56, 2'b00);
        for (int s = 0; s < 12; s++) begin
            if (s == 2) begin
                Sec = 8'h57;
                push_frame(8'h12, 8'h34, 8'h57, 2'b00);
            end
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL midframe slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_invalid_digit();
        logic [13:0] e;
        push_frame(8'h12, 8'h34, 8'h57, 2'b00);
        for (int s = 0; s < 12; s++) begin
            if (s == 1) begin
                Sec = 8'h5A;
                push_frame(8'h12, 8'h34, 8'h5A, 2'b00);
            end
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL invalid slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask

    // EN drops for 10 CP inside slot 2; then the slot finishes its remaining 2 counts.
    task automatic test_enable_freeze();
        logic [13:0] e;
        int          cycles;
        push_frame(8'h12, 8'h34, 8'h5A, 2'b00);
        for (int s = 0; s < 12; s++) begin
            if (s == 1) begin
                Hour = 8'h23; Min = 8'h59; Sec = 8'h09;
                push_frame(8'h23, 8'h59, 8'h09, 2'b00);
            end
            e = take();
            cycles = (s == 2) ? 14 : 4;
            for (int c = 0; c < cycles; c++) begin
                if (s == 2 && c == 2)  EN = 1'b0;
                if (s == 2 && c == 12) EN = 1'b1;
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL enable slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [13:0] e;
        push_frame(8'h23, 8'h59, 8'h09, 2'b00);
        for (int s = 0; s < 3; s++) begin
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL pre_reset slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({AN, Seg, DP} !== ALL_OFF)
            $display("FAIL async_reset: AN=%h Seg=%h DP=%b want 3f 7f 1", AN, Seg, DP);
        else n_pass++;
        @(posedge CP); @(negedge CP);
        reset = 1'b0;
        exp_q.delete();
        push_frame(8'h00, 8'h00, 8'h00, 2'b00);
        push_frame(8'h23, 8'h59, 8'h09, 2'b00);
        for (int s = 0; s < 12; s++) begin
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL restart slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask

`ifdef SEG7_BLINK_EN
    // Phase flips every 2 frames from reset: frames 3,4 and 7 hide the minute digits.
    task automatic test_blink();
        logic [13:0] e;
        BlinkSel = 2'b10;
        reset = 1'b1;
        @(posedge CP); @(negedge CP);
        reset = 1'b0;
        exp_q.delete();
        push_frame(8'h00, 8'h00, 8'h00, 2'b00);
        push_frame(8'h23, 8'h59, 8'h09, 2'b00);
        push_frame(8'h23, 8'h59, 8'h09, 2'b10);
        push_frame(8'h23, 8'h59, 8'h09, 2'b10);
        push_frame(8'h23, 8'h59, 8'h09, 2'b00);
        push_frame(8'h23, 8'h59, 8'h09, 2'b00);
        push_frame(8'h23, 8'h59, 8'h09, 2'b10);
        for (int s = 0; s < 42; s++) begin
            e = take();
            for (int c = 0; c < 4; c++) begin
                @(posedge CP); @(negedge CP);
                n_checks++;
                if ({AN, Seg, DP} !== e)
                    $display("FAIL blink slot %0d cyc %0d: AN=%h Seg=%h DP=%b want AN=%h Seg=%h DP=%b",
                             s, c, AN, Seg, DP, e[13:8], e[7:1], e[0]);
                else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        EN    = 1'b0;
        Hour  = 8'h12;
        Min   = 8'h34;
        Sec   = 8'h56;
`ifdef SEG7_BLINK_EN
        BlinkSel = 2'b00;
`endif
        @(negedge CP);
        test_reset();
        test_scan();
        test_midframe_change();
        test_invalid_digit();
        test_enable_freeze();
        test_reset_midframe();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
